demux1x4_16_buf: RTL and testbench

Buffered 1-to-4 word distributor: the inverse of the 16-bit 4:1 word selector. Each 16-bit input word carries a 2-bit destination select and is steered into one of four independent 2-deep output queues. Each queue drains through its own valid/ready port. Sits wherever a shared 16-bit bus must fan out to four consumers without losing words when a consumer stalls.

---
 rtl/demux1x4_16_buf.sv | 127 ++++++++++++
 tb/tb_demux1x4_16_buf.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/demux1x4_16_buf.sv
// demux1x4_16_buf: steers each 16-bit input word to one of four independent
// 2-deep FIFOs chosen by s. Each FIFO drains through its own valid/ready port.
// cnt counts accepted words modulo 256.
module demux1x4_16_buf (
   input  logic        clk,
   input  logic        rstn,
   input  logic [15:0] i,
   input  logic [1:0]  s,
   input  logic        iv,
   output logic        ir,
   output logic [15:0] o0,
   output logic [15:0] o1,
   output logic [15:0] o2,
   output logic [15:0] o3,
   output logic        v0,
   output logic        v1,
   output logic        v2,
   output logic        v3,
   input  logic        r0,
   input  logic        r1,
   input  logic        r2,
   input  logic        r3,
   output logic [7:0]  cnt
);

   // Per-channel occupancy (0..2), head entry and tail entry.
   logic [1:0]  count_q [4];
   logic [1:0]  count_d [4];
   logic [15:0] head_q  [4];
   logic [15:0] head_d  [4];
   logic [15:0] tail_q  [4];
   logic [15:0] tail_d  [4];
   logic [7:0]  cnt_q;
   logic [7:0]  cnt_d;

   logic       accept;
   logic [3:0] push;
   logic [3:0] pop;
   logic [3:0] rdy;

   assign rdy = {r3, r2, r1, r0};

   // Ready depends only on the selected channel's registered occupancy, so a
   // consumer's ready never combinationally reaches the input side.
   assign ir     = (count_q[s] != 2'd2);
   assign accept = iv && ir;
   assign push   = accept ? (4'b0001 << s) : 4'b0000;

   // A pop needs a resident head and the consumer's ready.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         pop[k] = (count_q[k] != 2'd0) && rdy[k];
      end
   end

   // Next-state for every queue plus the accept counter.
   always_comb begin
      // NOTE: every variable gets a default before any conditional update, so
      // no path leaves a value unassigned and no latch is inferred.
      cnt_d = accept ? cnt_q + 8'd1 : cnt_q;
      for (int k = 0; k < 4; k++) begin
         count_d[k] = count_q[k];
         head_d[k]  = head_q[k];
         tail_d[k]  = tail_q[k];
         case (count_q[k])
            2'd0: begin
               if (push[k]) begin
                  head_d[k]  = i;
                  count_d[k] = 2'd1;
               end
            end
            2'd1: begin
               if (push[k] && pop[k]) begin
                  // Old head leaves, new word takes its place.
                  head_d[k] = i;
               end else if (push[k]) begin
                  tail_d[k]  = i;
                  count_d[k] = 2'd2;
               end else if (pop[k]) begin
                  count_d[k] = 2'd0;
               end
            end
            default: begin
               // Full: no push can reach this queue, only a pop.
               if (pop[k]) begin
                  head_d[k]  = tail_d[k];
                  count_d[k] = 2'd1;
               end
            end
         endcase
      end
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         cnt_q <= 8'd0;
         // NOTE: the data registers are cleared too, because the heads are
         // directly visible on o0..o3 and must read zero after reset.
         for (int k = 0; k < 4; k++) begin
            count_q[k] <= 2'd0;
            head_q[k]  <= 16'h0000;
            tail_q[k]  <= 16'h0000;
         end
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values regardless of statement order.
         cnt_q <= cnt_d;
         for (int k = 0; k < 4; k++) begin
            count_q[k] <= count_d[k];
            head_q[k]  <= head_d[k];
            tail_q[k]  <= tail_d[k];
         end
      end
   end

   assign o0  = head_q[0];
   assign o1  = head_q[1];
   assign o2  = head_q[2];
   assign o3  = head_q[3];
   assign v0  = (count_q[0] != 2'd0);
   assign v1  = (count_q[1] != 2'd0);
   assign v2  = (count_q[2] != 2'd0);
   assign v3  = (count_q[3] != 2'd0);
   assign cnt = cnt_q;

endmodule

// File: tb/tb_demux1x4_16_buf.sv
// Bench for demux1x4_16_buf: directed vector table, hand sequences for
// back-pressure / mid-traffic reset / counter wrap, then random traffic
// checked against a queue-based reference model.
module tb_demux1x4_16_buf;

   logic        clk = 1'b0;
   logic        rstn;
   logic [15:0] i;
   logic [1:0]  s;
   logic        iv;
   logic        ir;
   logic [15:0] o0, o1, o2, o3;
   logic        v0, v1, v2, v3;
   logic [3:0]  r_in;
   logic [7:0]  cnt;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   demux1x4_16_buf dut (
      .clk (clk),  .rstn(rstn), .i(i), .s(s), .iv(iv), .ir(ir),
      .o0  (o0),   .o1  (o1),   .o2(o2), .o3(o3),
      .v0  (v0),   .v1  (v1),   .v2(v2), .v3(v3),
      .r0  (r_in[0]), .r1(r_in[1]), .r2(r_in[2]), .r3(r_in[3]),
      .cnt (cnt)
   );

   logic [15:0] o_w [4];
   logic [3:0]  v_w;
   assign o_w[0] = o0;
   assign o_w[1] = o1;
   assign o_w[2] = o2;
   assign o_w[3] = o3;
   assign v_w    = {v3, v2, v1, v0};

   // Reference model: one queue per channel plus an accept counter.
   logic [15:0] mq [4][$];
   int          m_cnt      = 0;
   bit          m_known    = 0;
   bit          m_just_rst = 0;
   logic        ir_seen;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, check ir against the model, advance the
   // model, clock, then compare all outputs with the model.
   task automatic cycle(input logic rst_v, input logic iv_v, input logic [1:0] s_v,
                        input logic [15:0] d_v, input logic [3:0] r_v);
      bit m_ir;
      rstn = rst_v; iv = iv_v; s = s_v; i = d_v; r_in = r_v;
      #1;
      ir_seen = ir;
      m_ir = (mq[s_v].size() != 2);
      if (m_known && rst_v) check("model_ir", {31'd0, ir}, {31'd0, m_ir});
      if (!rst_v) begin
         for (int k = 0; k < 4; k++) mq[k].delete();
         m_cnt      = 0;
         m_known    = 1;
         m_just_rst = 1;
      end else begin
         m_just_rst = 0;
         for (int k = 0; k < 4; k++)
            if (mq[k].size() > 0 && r_v[k]) void'(mq[k].pop_front());
         if (iv_v && m_ir) begin
            mq[s_v].push_back(d_v);
            m_cnt = (m_cnt + 1) % 256;
         end
      end
      @(posedge clk);
      #1;
      if (m_known) begin
         check("model_cnt", {24'd0, cnt}, m_cnt);
         for (int k = 0; k < 4; k++) begin
            check($sformatf("model_v%0d", k), {31'd0, v_w[k]}, {31'd0, mq[k].size() != 0});
            if (mq[k].size() != 0)
               check($sformatf("model_o%0d", k), {16'd0, o_w[k]}, {16'd0, mq[k][0]});
            else if (m_just_rst)
               check($sformatf("model_o%0d_rst", k), {16'd0, o_w[k]}, 32'd0);
         end
      end
   endtask

   typedef struct {
      logic        rst_n;
      logic        iv;
      logic [1:0]  s;
      logic [15:0] d;
      logic [3:0]  r;
      logic        chk_ir;
      logic        exp_ir;
      logic [3:0]  exp_v;
      logic [7:0]  exp_cnt;
      logic [63:0] exp_o;   // {o3, o2, o1, o0}
   } vec_t;

   vec_t tbl [10];

   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      rstn = 1'b0; iv = 1'b0; s = 2'd0; i = 16'h0; r_in = 4'h0;

      // Reset/idle, basic steer, simultaneous push/pop.
      tbl[0] = '{1'b0, 1'b1, 2'd2, 16'hFFFF, 4'hF, 1'b0, 1'b0, 4'h0, 8'd0, 64'h0};
      tbl[1] = '{1'b0, 1'b1, 2'd2, 16'hFFFF, 4'hF, 1'b1, 1'b1, 4'h0, 8'd0, 64'h0};
      tbl[2] = '{1'b1, 1'b1, 2'd0, 16'hA000, 4'hF, 1'b1, 1'b1, 4'h1, 8'd1, {16'h0, 16'h0, 16'h0, 16'hA000}};
      tbl[3] = '{1'b1, 1'b1, 2'd1, 16'hA001, 4'hF, 1'b1, 1'b1, 4'h2, 8'd2, {16'h0, 16'h0, 16'hA001, 16'h0}};
      tbl[4] = '{1'b1, 1'b1, 2'd2, 16'hA002, 4'hF, 1'b1, 1'b1, 4'h4, 8'd3, {16'h0, 16'hA002, 16'h0, 16'h0}};
      tbl[5] = '{1'b1, 1'b1, 2'd3, 16'hA003, 4'hF, 1'b1, 1'b1, 4'h8, 8'd4, {16'hA003, 16'h0, 16'h0, 16'h0}};
      tbl[6] = '{1'b1, 1'b0, 2'd0, 16'h0000, 4'hF, 1'b1, 1'b1, 4'h0, 8'd4, 64'h0};
      tbl[7] = '{1'b1, 1'b1, 2'd0, 16'h0BAD, 4'h0, 1'b1, 1'b1, 4'h1, 8'd5, {16'h0, 16'h0, 16'h0, 16'h0BAD}};
      tbl[8] = '{1'b1, 1'b1, 2'd0, 16'h0C0D, 4'h1, 1'b1, 1'b1, 4'h1, 8'd6, {16'h0, 16'h0, 16'h0, 16'h0C0D}};
      tbl[9] = '{1'b1, 1'b0, 2'd0, 16'h0000, 4'h1, 1'b1, 1'b1, 4'h0, 8'd6, 64'h0};

      for (int n = 0; n < 10; n++) begin
         logic [63:0] eo;
         eo = tbl[n].exp_o;
         cycle(tbl[n].rst_n, tbl[n].iv, tbl[n].s, tbl[n].d, tbl[n].r);
         if (tbl[n].chk_ir) check($sformatf("vec%0d_ir", n), {31'd0, ir_seen}, {31'd0, tbl[n].exp_ir});
         check($sformatf("vec%0d_v", n), {28'd0, v_w}, {28'd0, tbl[n].exp_v});
         check($sformatf("vec%0d_cnt", n), {24'd0, cnt}, {24'd0, tbl[n].exp_cnt});
         for (int k = 0; k < 4; k++)
            if (tbl[n].exp_v[k] || !tbl[n].rst_n)
               check($sformatf("vec%0d_o%0d", n, k), {16'd0, o_w[k]}, {16'd0, eo[16*k +: 16]});
      end

      // Back-pressure on channel 2 with r2 held low.
      cycle(1'b1, 1'b1, 2'd2, 16'h1111, 4'b1011);
      cycle(1'b1, 1'b1, 2'd2, 16'h2222, 4'b1011);
      cycle(1'b1, 1'b1, 2'd2, 16'h3333, 4'b1011);
      check("bp_full_ir", {31'd0, ir_seen}, 32'd0);
      check("bp_held_cnt", {24'd0, cnt}, 32'd8);
      check("bp_head", {16'd0, o2}, 32'h1111);
      cycle(1'b1, 1'b1, 2'd1, 16'h5555, 4'b1011);
      check("bp_other_ir", {31'd0, ir_seen}, 32'd1);
      check("bp_other_o1", {15'd0, v1, o1}, 32'h1_5555);
      cycle(1'b1, 1'b1, 2'd2, 16'h3333, 4'hF);
      check("bp_drain1_ir", {31'd0, ir_seen}, 32'd0);
      check("bp_drain1_o2", {15'd0, v2, o2}, 32'h1_2222);
      cycle(1'b1, 1'b1, 2'd2, 16'h3333, 4'hF);
      check("bp_drain2_ir", {31'd0, ir_seen}, 32'd1);
      check("bp_drain2_o2", {15'd0, v2, o2}, 32'h1_3333);
      cycle(1'b1, 1'b0, 2'd2, 16'h0000, 4'hF);
      check("bp_empty_v", {28'd0, v_w}, 32'd0);

      // Reset in the middle of traffic with c1 = 2 and c3 = 1.
      cycle(1'b1, 1'b1, 2'd1, 16'h7001, 4'h0);
      cycle(1'b1, 1'b1, 2'd1, 16'h7002, 4'h0);
      cycle(1'b1, 1'b1, 2'd3, 16'h7003, 4'h0);
      check("rm_pre_v", {28'd0, v_w}, 32'hA);
      cycle(1'b0, 1'b1, 2'd3, 16'h7004, 4'hF);
      check("rm_v", {28'd0, v_w}, 32'd0);
      check("rm_cnt", {24'd0, cnt}, 32'd0);
      for (int n = 0; n < 3; n++) begin
         cycle(1'b1, 1'b0, 2'd1, 16'h0000, 4'hF);
         check($sformatf("rm_stale%0d", n), {28'd0, v_w}, 32'd0);
      end

      // Counter wrap: 256 accepts with every consumer ready.
      for (int n = 1; n <= 256; n++) begin
         cycle(1'b1, 1'b1, 2'($urandom_range(0, 3)), 16'($urandom), 4'hF);
         if (n == 255) check("wrap_255", {24'd0, cnt}, 32'd255);
         if (n == 256) check("wrap_0", {24'd0, cnt}, 32'd0);
      end

      // Random traffic with stalls and occasional resets.
      for (int n = 0; n < 600; n++) begin
         logic [3:0] rr;
         for (int k = 0; k < 4; k++) rr[k] = ($urandom_range(0, 9) < 6);
         cycle(($urandom_range(0, 79) != 0), 1'($urandom), 2'($urandom_range(0, 3)),
               16'($urandom), rr);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
